// File: rtl/matrix_op_engine.sv
// Sequential NxN matrix add / subtract / multiply engine.
// Latches two packed operand matrices, computes the result two elements at a
// time with a single MAC, and emits {C[k], C[k-1]} pairs from the highest index
// down to the lowest.
// Ports:
//   clock, rst      : clock and synchronous active-high reset
//   start, op       : request and opcode (00 add, 01 sub, 10 mul, 11 illegal)
//   mat_a, mat_b    : packed operands, element k at [k*DATA_W +: DATA_W]
//   busy            : high whenever the engine is not idle
//   res_pair        : {C[k], C[k-1]}, held between strobes
//   res_pair_valid  : one-cycle push strobe for res_pair
//   done            : one-cycle pulse after the last pair
//   err             : one-cycle pulse when start arrives with the illegal opcode
module matrix_op_engine #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned RES_W  = 2 * DATA_W + $clog2(N)
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                op,
    input  logic [N*N*DATA_W-1:0]     mat_a,
    input  logic [N*N*DATA_W-1:0]     mat_b,
    output logic                      busy,
    output logic [2*RES_W-1:0]        res_pair,
    output logic                      res_pair_valid,
    output logic                      done,
    output logic                      err
);

    localparam int unsigned NN    = N * N;
    localparam int unsigned KW    = (NN > 1) ? $clog2(NN) : 1;
    localparam int unsigned MW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned MAT_W = NN * DATA_W;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [1:0] {IDLE, ACC, PUSH, DONE} state_t;

    state_t             state;
    logic [1:0]         op_r;
    logic [MAT_W-1:0]   a_r;
    logic [MAT_W-1:0]   b_r;
    logic [KW-1:0]      k_r;
    logic               sel_r;      // 0: computing C[k], 1: computing C[k-1]
    logic [MW-1:0]      m_r;
    logic [RES_W-1:0]   acc_r;
    logic [RES_W-1:0]   hi_r;
    logic [RES_W-1:0]   lo_r;

    logic [DATA_W-1:0]   a_arr [NN];
    logic [DATA_W-1:0]   b_arr [NN];
    logic [KW-1:0]       e_idx;
    logic [KW-1:0]       a_idx;
    logic [KW-1:0]       b_idx;
    logic [DATA_W-1:0]   a_el;
    logic [DATA_W-1:0]   b_el;
    logic [2*DATA_W-1:0] prod;
    logic [RES_W-1:0]    elem;
    logic                elem_last;
    int unsigned         e_int;
    int unsigned         m_int;

    // Operand fetch and one MAC / add / sub step for the element in progress.
    always_comb begin
        for (int unsigned i = 0; i < NN; i++) begin
            a_arr[i] = a_r[i*DATA_W +: DATA_W];
            b_arr[i] = b_r[i*DATA_W +: DATA_W];
        end
        e_idx = sel_r ? (k_r - KW'(1)) : k_r;
        e_int = 32'(e_idx);
        m_int = 32'(m_r);
        if (op_r == OP_ADD || op_r == OP_SUB) begin
            a_idx = e_idx;
            b_idx = e_idx;
        end else begin
            // row of A walks along m, column of B walks down m
            a_idx = KW'((e_int / N) * N + m_int);
            b_idx = KW'(m_int * N + (e_int % N));
        end
        a_el = a_arr[a_idx];
        b_el = b_arr[b_idx];
        prod = {DATA_W'(0), a_el} * {DATA_W'(0), b_el};
        case (op_r)
            OP_ADD:  elem = RES_W'(a_el) + RES_W'(b_el);
            OP_SUB:  elem = RES_W'(a_el) - RES_W'(b_el);
            default: elem = acc_r + RES_W'(prod);
        endcase
        elem_last = (op_r == OP_ADD) || (op_r == OP_SUB) || (m_r == MW'(N - 1));
    end

    // Control FSM; outputs are registered from the current state.
    always_ff @(posedge clock) begin
        if (rst) begin
            state          <= IDLE;
            op_r           <= '0;
            a_r            <= '0;
            b_r            <= '0;
            k_r            <= '0;
            sel_r          <= 1'b0;
            m_r            <= '0;
            acc_r          <= '0;
            hi_r           <= '0;
            lo_r           <= '0;
            busy           <= 1'b0;
            res_pair       <= '0;
            res_pair_valid <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            busy           <= (state != IDLE);
            done           <= (state == DONE);
            res_pair_valid <= 1'b0;
            err            <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_ILL) begin
                            err <= 1'b1;
                        end else begin
                            a_r   <= mat_a;
                            b_r   <= mat_b;
                            op_r  <= op;
                            k_r   <= KW'(NN - 1);
                            sel_r <= 1'b0;
                            m_r   <= '0;
                            acc_r <= '0;
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (elem_last) begin
                        acc_r <= '0;
                        m_r   <= '0;
                        sel_r <= ~sel_r;
                        if (!sel_r) begin
                            hi_r <= elem;
                        end else begin
                            lo_r  <= elem;
                            state <= PUSH;
                        end
                    end else begin
                        acc_r <= elem;
                        m_r   <= m_r + MW'(1);
                    end
                end
                PUSH: begin
                    res_pair       <= {hi_r, lo_r};
                    res_pair_valid <= 1'b1;
                    if (k_r == KW'(1)) begin
                        state <= DONE;
                    end else begin
                        k_r   <= k_r - KW'(2);
                        state <= ACC;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
